// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester and a
//   load/store requester. Only one access is outstanding at a time. The
//   granted request is captured into registers, and those registers drive
//   the memory port until memReady completes the access.
//
//   Optional feature macro: MEMARB_RR_EN
//     defined   : when both ports request, the port that was not granted
//                 last wins. The last-granted flag resets to fetch.
//     undefined : data always wins over fetch.
//
//   Ports
//     clk, reset                       clock; async active-high reset
//     iReq/iAddr -> iData/iValid/iStall    fetch side
//     dReq/dWe/dType/dAddr/dWData
//       -> dRData/dValid/dStall            load/store side
//     memReq/memWe/memType/memAddr/memWData -> memory (registered)
//     memReady/memRData                     <- memory completion + data
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic [31:0]       iData,
    output logic              iValid,
    output logic              iStall,
    // data port
    input  logic              dReq,
    input  logic              dWe,
    input  logic [2:0]        dType,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWData,
    output logic [DATA_W-1:0] dRData,
    output logic              dValid,
    output logic              dStall,
    // shared memory port
    output logic              memReq,
    output logic              memWe,
    output logic [2:0]        memType,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic              memReady,
    input  logic [DATA_W-1:0] memRData
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t state, stateNext;
    logic   iPend, dPend;
    logic   grantI, grantD;
    logic   preferI;

    // A requester still holds its request during the cycle its valid
    // pulses. Masking the request with its own valid keeps that completed
    // request from being granted a second time. A request that is still
    // high one cycle later is a new request.
    assign iPend  = iReq & ~iValid;
    assign dPend  = dReq & ~dValid;
    assign iStall = iPend;
    assign dStall = dPend;

`ifdef MEMARB_RR_EN
    logic lastGrantD;  // 0 = fetch was granted last

    assign preferI = lastGrantD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       lastGrantD <= 1'b0;
        else if (grantD) lastGrantD <= 1'b1;
        else if (grantI) lastGrantD <= 1'b0;
    end
`else
    assign preferI = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        grantI    = 1'b0;
        grantD    = 1'b0;
        case (state)
            IDLE: begin
                if (iPend && dPend) begin
                    grantI = preferI;
                    grantD = ~preferI;
                end else begin
                    grantI = iPend;
                    grantD = dPend;
                end
                if (grantD)      stateNext = BUSY_D;
                else if (grantI) stateNext = BUSY_I;
            end
            BUSY_I, BUSY_D: if (memReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Memory-port request registers and response capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memType  <= '0;
            memAddr  <= '0;
            memWData <= '0;
            iData    <= '0;
            dRData   <= '0;
            iValid   <= 1'b0;
            dValid   <= 1'b0;
        end else begin
            iValid <= 1'b0;
            dValid <= 1'b0;
            if (grantD) begin
                memReq   <= 1'b1;
                memWe    <= dWe;
                memType  <= dType;
                memAddr  <= dAddr;
                memWData <= dWData;
            end else if (grantI) begin
                memReq   <= 1'b1;
                memWe    <= 1'b0;
                memType  <= 3'b010;  // fetches are always a word
                memAddr  <= iAddr;
                memWData <= '0;
            end
            if (memReady && state == BUSY_I) begin
                memReq <= 1'b0;
                iData  <= memRData[31:0];
                iValid <= 1'b1;
            end
            if (memReady && state == BUSY_D) begin
                memReq <= 1'b0;
                dValid <= 1'b1;
                // A store completion leaves the last load data in place.
                if (!memWe) dRData <= memRData;
            end
        end
    end

endmodule
